// File: rtl/hdd_seek_sequencer_pkg.sv
// Shared types and constants for the ST-506/ESDI head-positioning sequencer.
package hdd_seek_pkg;

  localparam int unsigned CLK_MHZ = 300;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DIR_SETUP,
    S_STEP_HI,
    S_STEP_LO,
    S_SC_BLANK,
    S_WAIT_SC,
    S_DONE,
    S_FAIL
  } seek_state_t;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_NOT_READY = 3'd1;
  localparam logic [2:0] ERR_NO_REF    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd3;
  localparam logic [2:0] ERR_TRACK0_NF = 3'd4;

  function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/hdd_seek_sequencer_if.sv
// Host register-block side of the seek sequencer: command strobes and status.
interface hdd_seek_sequencer_if;
  logic        cmd_seek;
  logic        cmd_recal;
  logic [15:0] target_cyl;
  logic [19:0] step_period;
  logic        cmd_busy;
  logic [15:0] cur_cyl;
  logic        cyl_valid;
  logic [2:0]  error_code;

  modport master (
    output cmd_seek, cmd_recal, target_cyl, step_period,
    input  cmd_busy, cur_cyl, cyl_valid, error_code
  );

  modport slave (
    input  cmd_seek, cmd_recal, target_cyl, step_period,
    output cmd_busy, cur_cyl, cyl_valid, error_code
  );
endinterface

// File: rtl/hdd_seek_sequencer_sync_2ff.sv
// Two-flop synchronizer bank for asynchronous drive status lines.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/hdd_seek_sequencer.sv
// Seek/recalibrate sequencer: drives STEP/DIR, tracks cylinder, waits for SEEK_COMPLETE.
module hdd_seek_sequencer
  import hdd_seek_pkg::*;
#(
  parameter int unsigned STEP_PULSE_CLKS   = 600,
  parameter int unsigned DIR_SETUP_CLKS    = 300,
  parameter int unsigned SC_BLANK_CLKS     = 3000,
  parameter int unsigned SEEK_TIMEOUT_CLKS = 300000000,
  parameter int unsigned MAX_RECAL_STEPS   = 2048
) (
  input  logic                 clk,
  input  logic                 reset,
  hdd_seek_sequencer_if.slave  host,
  output logic                 drv_step,
  output logic                 drv_dir,
  input  logic                 drv_seek_complete,
  input  logic                 drv_track0,
  input  logic                 drv_ready,
  output logic                 seek_start,
  output logic                 seek_complete,
  output logic                 seek_error,
  output logic [15:0]          seek_distance
);

  logic [2:0]  sync_q;
  logic        sc_s, t0_s, rdy_s;
  seek_state_t state, next_state;
  logic [2:0]  fail_code;
  logic [31:0] timer, timer_load, period_clks, lo_clks;
  logic        is_recal, busy, cyl_valid;
  logic [15:0] tgt, cur_cyl, steps_left, recal_steps, acc_dist;
  logic [19:0] period;
  logic [2:0]  err;
  logic        start_d, comp_d, err_d, step_d, busy_d, accept, entering;

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   ({drv_seek_complete, drv_track0, drv_ready}),
    .q   (sync_q)
  );
  assign {sc_s, t0_s, rdy_s} = sync_q;

  assign host.cmd_busy   = busy;
  assign host.cur_cyl    = cur_cyl;
  assign host.cyl_valid  = cyl_valid;
  assign host.error_code = err;

  assign accept      = (state == S_IDLE) && (host.cmd_seek || host.cmd_recal);
  assign entering    = (next_state != state);
  assign acc_dist    = host.cmd_recal ? (cyl_valid ? cur_cyl : 16'hFFFF)
                                      : abs_diff(host.target_cyl, cur_cyl);
  assign period_clks = ({12'd0, period} > 2 * STEP_PULSE_CLKS) ? {12'd0, period}
                                                               : 2 * STEP_PULSE_CLKS;
  assign lo_clks     = period_clks - STEP_PULSE_CLKS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    fail_code  = ERR_NONE;
    unique case (state)
      S_IDLE:      if (accept) next_state = S_START;
      S_START: begin
        if (!rdy_s) begin
          next_state = S_FAIL;
          fail_code  = ERR_NOT_READY;
        end else if (!is_recal && !cyl_valid) begin
          next_state = S_FAIL;
          fail_code  = ERR_NO_REF;
        end else if (!is_recal && seek_distance == 16'd0) begin
          next_state = S_WAIT_SC;
        end else begin
          next_state = S_DIR_SETUP;
        end
      end
      S_DIR_SETUP: if (timer == 32'd0) next_state = (is_recal && t0_s) ? S_SC_BLANK : S_STEP_HI;
      S_STEP_HI:   if (timer == 32'd0) next_state = S_STEP_LO;
      S_STEP_LO: begin
        if (timer == 32'd0) begin
          if (is_recal) begin
            if (t0_s) begin
              next_state = S_SC_BLANK;
            end else if (32'(recal_steps) >= MAX_RECAL_STEPS) begin
              next_state = S_FAIL;
              fail_code  = ERR_TRACK0_NF;
            end else begin
              next_state = S_STEP_HI;
            end
          end else begin
            next_state = (steps_left == 16'd0) ? S_SC_BLANK : S_STEP_HI;
          end
        end
      end
      S_SC_BLANK:  if (timer == 32'd0) next_state = S_WAIT_SC;
      S_WAIT_SC: begin
        if (sc_s) begin
          next_state = S_DONE;
        end else if (timer == 32'd0) begin
          next_state = S_FAIL;
          fail_code  = ERR_TIMEOUT;
        end
      end
      S_DONE:      next_state = S_IDLE;
      S_FAIL:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
    // Drive dropping out overrides whatever the active state decided.
    if (!(state inside {S_IDLE, S_DONE, S_FAIL}) && !rdy_s) begin
      next_state = S_FAIL;
      fail_code  = ERR_NOT_READY;
    end
  end

  always_comb begin
    start_d = (next_state == S_START);
    comp_d  = (next_state == S_DONE);
    err_d   = (next_state == S_FAIL);
    step_d  = (next_state == S_STEP_HI);
    busy_d  = !(next_state inside {S_IDLE, S_DONE, S_FAIL});
    unique case (next_state)
      S_DIR_SETUP: timer_load = DIR_SETUP_CLKS - 1;
      S_STEP_HI:   timer_load = STEP_PULSE_CLKS - 1;
      S_STEP_LO:   timer_load = lo_clks - 32'd1;
      S_SC_BLANK:  timer_load = SC_BLANK_CLKS - 1;
      S_WAIT_SC:   timer_load = SEEK_TIMEOUT_CLKS - 1;
      default:     timer_load = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;  is_recal <= 1'b0;  tgt <= '0;  period <= '0;
      steps_left <= '0;  recal_steps <= '0;  cur_cyl <= '0;  cyl_valid <= 1'b0;
      busy <= 1'b0;  err <= ERR_NONE;  drv_step <= 1'b0;  drv_dir <= 1'b0;
      seek_start <= 1'b0;  seek_complete <= 1'b0;  seek_error <= 1'b0;
      seek_distance <= '0;
    end else begin
      seek_start    <= start_d;
      seek_complete <= comp_d;
      seek_error    <= err_d;
      drv_step      <= step_d;
      busy          <= busy_d;
      if (entering)              timer <= timer_load;
      else if (timer != 32'd0)   timer <= timer - 32'd1;
      if (accept) begin
        is_recal      <= host.cmd_recal;
        tgt           <= host.target_cyl;
        period        <= host.step_period;
        err           <= ERR_NONE;
        recal_steps   <= '0;
        steps_left    <= acc_dist;
        seek_distance <= acc_dist;
      end
      if (state == S_START && next_state == S_DIR_SETUP)
        drv_dir <= is_recal ? 1'b0 : (tgt > cur_cyl);
      if (entering && next_state == S_STEP_HI) begin
        steps_left  <= steps_left - 16'd1;
        recal_steps <= recal_steps + 16'd1;
        if (drv_dir)                cur_cyl <= cur_cyl + 16'd1;
        else if (cur_cyl != 16'd0)  cur_cyl <= cur_cyl - 16'd1;
      end
      if (next_state == S_DONE && is_recal) begin
        cur_cyl   <= '0;
        cyl_valid <= 1'b1;
      end
      if (entering && next_state == S_FAIL) begin
        err       <= fail_code;
        cyl_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdd_seek_sequencer.sv
// Directed bench for hdd_seek_sequencer with shortened timing parameters.
module tb_hdd_seek_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        drv_step, drv_dir, sc, t0, rdy;
  logic        seek_start, seek_complete, seek_error;
  logic [15:0] seek_distance;

  always #5 clk = ~clk;

  hdd_seek_sequencer_if host_if ();

  hdd_seek_sequencer #(
    .STEP_PULSE_CLKS   (4),
    .DIR_SETUP_CLKS    (2),
    .SC_BLANK_CLKS     (8),
    .SEEK_TIMEOUT_CLKS (1000),
    .MAX_RECAL_STEPS   (2048)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .host              (host_if),
    .drv_step          (drv_step),
    .drv_dir           (drv_dir),
    .drv_seek_complete (sc),
    .drv_track0        (t0),
    .drv_ready         (rdy),
    .seek_start        (seek_start),
    .seek_complete     (seek_complete),
    .seek_error        (seek_error),
    .seek_distance     (seek_distance)
  );

  int   checks = 0, failures = 0;
  int   cyc = 0, starts = 0, comps = 0, errs = 0;
  int   pulses, hi_run, lo_run, hi_min, hi_max, lo_min, lo_max, dir_err;
  int   last_fall = 0, start_cyc = 0, end_cyc = 0;
  int   s0, c0, e0;
  logic step_q = 1'b0, exp_dir = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    pulses = 0; hi_run = 0; lo_run = 0; dir_err = 0;
    hi_min = 99999; hi_max = 0; lo_min = 99999; lo_max = 0;
    s0 = starts; c0 = comps; e0 = errs;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (seek_start)    begin starts++; start_cyc = cyc; end
    if (seek_complete) begin comps++;  end_cyc = cyc; end
    if (seek_error)    begin errs++;   end_cyc = cyc; end
    if (drv_step && !step_q) begin
      pulses++;
      if (pulses > 1) begin
        if (lo_run < lo_min) lo_min = lo_run;
        if (lo_run > lo_max) lo_max = lo_run;
      end
      hi_run = 1;
      if (drv_dir !== exp_dir) dir_err++;
    end else if (!drv_step && step_q) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      lo_run = 1;
      last_fall = cyc;
    end else if (drv_step) begin
      hi_run++;
    end else begin
      lo_run++;
    end
    step_q = drv_step;
  endtask

  task automatic issue(input logic seek, input logic recal, input logic [15:0] tgt,
                       input logic [19:0] per);
    host_if.cmd_seek    = seek;
    host_if.cmd_recal   = recal;
    host_if.target_cyl  = tgt;
    host_if.step_period = per;
    tick();
    host_if.cmd_seek  = 1'b0;
    host_if.cmd_recal = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < budget) begin
      tick();
      n++;
      if (seek_complete || seek_error) got = 1'b1;
    end
    if (!got) check_eq("wait_end_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pulses(input int count, input int budget);
    int n = 0;
    while (pulses < count && n < budget) begin
      tick();
      n++;
    end
    if (pulses < count) check_eq("wait_pulses_timeout", pulses, count);
  endtask

  initial begin
    reset = 1'b1; sc = 1'b1; t0 = 1'b0; rdy = 1'b1;
    host_if.cmd_seek = 1'b0; host_if.cmd_recal = 1'b0;
    host_if.target_cyl = '0; host_if.step_period = '0;
    repeat (3) tick();
    check_eq("rst_busy", host_if.cmd_busy, 0);
    check_eq("rst_cyl", host_if.cur_cyl, 0);
    check_eq("rst_valid", host_if.cyl_valid, 0);
    check_eq("rst_step", drv_step, 0);
    check_eq("rst_dir", drv_dir, 0);
    check_eq("rst_err", host_if.error_code, 0);
    check_eq("rst_dist", seek_distance, 0);
    reset = 1'b0;
    repeat (4) tick();

    // 1: recalibrate from reset, TRACK0 appears after the fifth step
    clear_stats(); exp_dir = 1'b0;
    issue(1'b0, 1'b1, 16'd0, 20'd20);
    check_eq("t1_start", seek_start, 1);
    check_eq("t1_dist", seek_distance, 16'hFFFF);
    check_eq("t1_busy", host_if.cmd_busy, 1);
    wait_pulses(5, 200);
    t0 = 1'b1;
    wait_end(500);
    check_eq("t1_pulses", pulses, 5);
    check_eq("t1_dir", dir_err, 0);
    check_eq("t1_comp", comps - c0, 1);
    check_eq("t1_starts", starts - s0, 1);
    check_eq("t1_cyl", host_if.cur_cyl, 0);
    check_eq("t1_valid", host_if.cyl_valid, 1);
    check_eq("t1_busy_end", host_if.cmd_busy, 0);
    repeat (3) tick();

    // 2: seek 0 -> 37
    clear_stats(); exp_dir = 1'b1;
    issue(1'b1, 1'b0, 16'd37, 20'd20);
    check_eq("t2_dist", seek_distance, 37);
    wait_end(2000);
    repeat (5) tick();
    check_eq("t2_pulses", pulses, 37);
    check_eq("t2_hi_min", hi_min, 4);
    check_eq("t2_hi_max", hi_max, 4);
    check_eq("t2_lo_min", lo_min, 16);
    check_eq("t2_lo_max", lo_max, 16);
    check_eq("t2_dir", dir_err, 0);
    check_eq("t2_cyl", host_if.cur_cyl, 37);
    check_eq("t2_comp", comps - c0, 1);
    check_eq("t2_errs", errs - e0, 0);

    // 3: zero-distance seek
    clear_stats();
    issue(1'b1, 1'b0, 16'd37, 20'd20);
    check_eq("t3_dist", seek_distance, 0);
    wait_end(50);
    check_eq("t3_gap_ge2", (end_cyc - start_cyc) >= 2, 1);
    check_eq("t3_pulses", pulses, 0);
    check_eq("t3_comp", comps - c0, 1);
    check_eq("t3_cyl", host_if.cur_cyl, 37);
    repeat (3) tick();

    // 4: timeout, then a seek without a valid reference
    sc = 1'b0;
    clear_stats(); exp_dir = 1'b1;
    issue(1'b1, 1'b0, 16'd40, 20'd20);
    check_eq("t4_dist", seek_distance, 3);
    wait_end(3000);
    check_eq("t4_errs", errs - e0, 1);
    check_eq("t4_timing", end_cyc - last_fall, 16 + 8 + 1000);
    check_eq("t4_code", host_if.error_code, 3);
    check_eq("t4_valid", host_if.cyl_valid, 0);
    check_eq("t4_pulses", pulses, 3);
    check_eq("t4_cyl", host_if.cur_cyl, 40);
    sc = 1'b1;
    repeat (3) tick();
    clear_stats();
    issue(1'b1, 1'b0, 16'd45, 20'd20);
    wait_end(50);
    check_eq("t4_noref_code", host_if.error_code, 2);
    check_eq("t4_noref_errs", errs - e0, 1);
    check_eq("t4_noref_pulses", pulses, 0);
    repeat (3) tick();

    // 5: re-reference, then lose READY at step 10 of 50
    clear_stats();
    issue(1'b0, 1'b1, 16'd0, 20'd20);
    wait_end(200);
    check_eq("t5_recal_valid", host_if.cyl_valid, 1);
    check_eq("t5_recal_cyl", host_if.cur_cyl, 0);
    repeat (3) tick();
    clear_stats(); exp_dir = 1'b1;
    issue(1'b1, 1'b0, 16'd50, 20'd20);
    wait_pulses(5, 200);
    issue(1'b1, 1'b0, 16'd7, 20'd20);
    wait_pulses(10, 200);
    rdy = 1'b0;
    wait_end(100);
    check_eq("t5_errs", errs - e0, 1);
    check_eq("t5_step_low", drv_step, 0);
    check_eq("t5_code", host_if.error_code, 1);
    check_eq("t5_busy", host_if.cmd_busy, 0);
    check_eq("t5_starts", starts - s0, 1);
    check_eq("t5_pulses", pulses, 10);
    check_eq("t5_cyl", host_if.cur_cyl, 10);
    check_eq("t5_valid", host_if.cyl_valid, 0);
    rdy = 1'b1; t0 = 1'b0;
    repeat (4) tick();

    // 6: asynchronous reset while STEP is high
    clear_stats(); exp_dir = 1'b0;
    issue(1'b0, 1'b1, 16'd0, 20'd20);
    wait_pulses(1, 100);
    check_eq("t6_step_before", drv_step, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("t6_step", drv_step, 0);
    check_eq("t6_busy", host_if.cmd_busy, 0);
    check_eq("t6_cyl", host_if.cur_cyl, 0);
    check_eq("t6_valid", host_if.cyl_valid, 0);
    check_eq("t6_dir", drv_dir, 0);
    check_eq("t6_dist", seek_distance, 0);
    check_eq("t6_err", host_if.error_code, 0);
    tick();
    reset = 1'b0;
    clear_stats();
    repeat (50) tick();
    check_eq("t6_no_start", starts - s0, 0);
    check_eq("t6_no_comp", comps - c0, 0);
    check_eq("t6_no_err", errs - e0, 0);
    check_eq("t6_no_pulse", pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdd_seek_sequencer.md
Name: hdd_seek_sequencer

Overview:
ST-506/ESDI head-positioning sequencer for the FluxRipper HDD interface (300 MHz domain). Accepts seek/recalibrate commands from the host register block and drives the drive's STEP/DIR lines. It tracks the current cylinder, waits for the drive's SEEK_COMPLETE, and enforces a timeout. Emits the seek_start/seek_complete/seek_error/seek_distance event stream consumed by the seek-statistics diagnostics.

Parameters:
STEP_PULSE_CLKS, 600, STEP high time in clocks (2 us).
DIR_SETUP_CLKS, 300, DIR-stable time before the first STEP (1 us).
SC_BLANK_CLKS, 3000, ignore SEEK_COMPLETE for this long after the last step (10 us).
SEEK_TIMEOUT_CLKS, 300000000, maximum wait for SEEK_COMPLETE after the last step (1 s).
MAX_RECAL_STEPS, 2048, step limit while searching for TRACK0.

Ports:
clk  in  1  HDD domain clock, 300 MHz
reset  in  1  asynchronous, active-high
cmd_seek  in  1  pulse: seek to target_cyl
cmd_recal  in  1  pulse: recalibrate to cylinder 0
target_cyl  in  16  seek target, sampled on accept
step_period  in  20  STEP period in clocks, sampled on accept
cmd_busy  out  1  command in progress
cur_cyl  out  16  current cylinder
cyl_valid  out  1  cur_cyl is trustworthy
error_code  out  3  0 none, 1 NOT_READY, 2 NO_REF, 3 TIMEOUT, 4 TRACK0_NOT_FOUND
drv_step  out  1  STEP to drive, active-high
drv_dir  out  1  1 = inward (cylinder+1), 0 = outward
drv_seek_complete  in  1  async from drive
drv_track0  in  1  async from drive
drv_ready  in  1  async from drive
seek_start  out  1  one-cycle event
seek_complete  out  1  one-cycle event
seek_error  out  1  one-cycle event
seek_distance  out  16  distance of the current/last operation

Behaviour:
- Reset (async) sets all outputs to 0 (cur_cyl=0, cyl_valid=0, drv_step=0, drv_dir=0) and the state to IDLE.
- drv_* inputs pass through 2-FF synchronizers. All references below are to the synchronized values.
- States: IDLE, START, DIR_SETUP, STEP_HI, STEP_LO, SC_BLANK, WAIT_SC, DONE, FAIL.
- Commands are accepted only in IDLE; otherwise they are ignored.
  - If cmd_seek and cmd_recal arrive together, recal wins.
  - On accept: cmd_busy=1, error_code=0, and target_cyl/step_period are latched.
- START (one cycle): pulse seek_start and drive seek_distance.
  - Seek: seek_distance = |target-cur_cyl|.
  - Recal: seek_distance = cyl_valid ? cur_cyl : 16'hFFFF.
  - seek_distance holds until the next seek_start.
  - seek_complete/seek_error never fire in the same cycle as seek_start; the earliest is the next cycle.
- START exits:
  - !drv_ready -> FAIL(1).
  - Seek with !cyl_valid -> FAIL(2).
  - Seek with distance 0 -> WAIT_SC.
  - Otherwise set drv_dir (seek: target>cur; recal: 0) and go to DIR_SETUP.
- DIR_SETUP waits DIR_SETUP_CLKS.
- STEP_HI: before entering, a recal with drv_track0=1 -> SC_BLANK instead.
  - drv_step=1 for STEP_PULSE_CLKS.
  - cur_cyl ±1 on entry; recal decrement saturates at 0.
- STEP_LO: drv_step=0 for max(step_period,2*STEP_PULSE_CLKS)-STEP_PULSE_CLKS.
  - Then the next step, or SC_BLANK when steps remaining=0 (seek).
  - Recal: track0 found, or MAX_RECAL_STEPS reached -> FAIL(4).
- SC_BLANK lasts SC_BLANK_CLKS, then WAIT_SC.
- WAIT_SC: drv_seek_complete=1 -> DONE.
  - After SEEK_TIMEOUT_CLKS -> FAIL(3).
  - The timeout counter is 32-bit and starts on WAIT_SC entry.
- DONE: pulse seek_complete; recal sets cur_cyl=0, cyl_valid=1; cmd_busy=0; go to IDLE.
- FAIL: pulse seek_error; latch error_code; cyl_valid=0; drv_step=0; cmd_busy=0; go to IDLE.
- drv_ready falling in any non-IDLE state -> next state FAIL(1).
  - drv_step is forced low in the same cycle as the abort.
- Exactly one of seek_complete/seek_error per seek_start.
- Event outputs are registered.

Decomposition:
- Package hdd_seek_pkg holds the state enum, error-code constants, and the CLK_MHZ=300 constant.
- One sub-module, sync_2ff (parameterized width), instantiated once with width 3 for the drive inputs.
- Timing counters are shared (one 32-bit down-counter reloaded per state).

Test Plan:
1. Bench params STEP_PULSE_CLKS=4, DIR_SETUP_CLKS=2, SC_BLANK_CLKS=8, SEEK_TIMEOUT_CLKS=1000. Recal from reset with track0 asserted after 5 steps, drive SC=1 -> 5 step pulses with dir=0, one seek_start with seek_distance=FFFF, seek_complete, cur_cyl=0, cyl_valid=1.
2. Seek 0->37, step_period=20 -> 37 pulses 4 high/16 low with dir=1, seek_distance=37, cur_cyl=37, exactly one seek_complete.
3. Seek 37->37 -> zero pulses, seek_distance=0, seek_complete ≥2 cycles after seek_start.
4. Seek with SC held low -> seek_error with error_code=3 exactly 1000 clks after WAIT_SC entry; cyl_valid=0; a following cmd_seek -> error_code=2.
5. drv_ready dropped mid-seek (step 10 of 50) -> drv_step low, seek_error with error_code=1, cmd_busy=0. A cmd_seek while busy is ignored (no second seek_start).
6. Assert reset during STEP_HI -> drv_step=0 and all outputs 0 immediately (asynchronously); no event pulses afterwards.
